// File: rtl/decode_stage_pkg.sv
// Shared constants for the decode stage: opcodes, bank encodings and
// instruction field positions.
package decode_stage_pkg;

    // Opcode map (inst[31:27])
    localparam logic [4:0] OP_NOP  = 5'd0;
    localparam logic [4:0] OP_ADD  = 5'd1;
    localparam logic [4:0] OP_SUB  = 5'd2;
    localparam logic [4:0] OP_MPY  = 5'd3;
    localparam logic [4:0] OP_AND  = 5'd4;
    localparam logic [4:0] OP_OR   = 5'd5;
    localparam logic [4:0] OP_XOR  = 5'd6;
    localparam logic [4:0] OP_SHL  = 5'd7;
    localparam logic [4:0] OP_SRL  = 5'd8;
    localparam logic [4:0] OP_SRA  = 5'd9;
    localparam logic [4:0] OP_CMP  = 5'd10;
    localparam logic [4:0] OP_MOV  = 5'd11;
    localparam logic [4:0] OP_BR   = 5'd12;
    localparam logic [4:0] OP_CALL = 5'd13;
    localparam logic [4:0] OP_RET  = 5'd14;
    localparam logic [4:0] OP_HALT = 5'd15;

    // Register bank encodings
    localparam logic S_REGS = 1'b0;
    localparam logic P_REGS = 1'b1;
    localparam int   P_NUM  = 8;

    // Link register index
    localparam int R31 = 31;

    // Instruction field bit positions
    localparam int OPC_HI  = 31;
    localparam int OPC_LO  = 27;
    localparam int IMM_BIT = 26;
    localparam int SX_BIT  = 25;
    localparam int ZA_HI   = 20;
    localparam int ZA_LO   = 16;
    localparam int NEG_BIT = 19;
    localparam int PA_HI   = 18;
    localparam int PA_LO   = 16;
    localparam int AD_HI   = 15;
    localparam int AD_LO   = 0;
    localparam int CC_HI   = 12;
    localparam int CC_LO   = 10;
    localparam int AA_HI   = 9;
    localparam int AA_LO   = 5;
    localparam int BA_HI   = 4;
    localparam int BA_LO   = 0;

    // True for the ALU opcode group (the ops that may carry a small immediate)
    function automatic logic is_alu_op(input logic [4:0] op);
        logic res;
        case (op)
            OP_ADD, OP_SUB, OP_MPY, OP_AND, OP_OR,
            OP_XOR, OP_SHL, OP_SRL, OP_SRA, OP_CMP: res = 1'b1;
            default:                                 res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/decode_stage_inst_fifo.sv
// Synchronous instruction FIFO with occupancy count and synchronous clear.
// The head entry is presented combinationally on rdata_o.
module inst_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == {CNT_W{1'b0}});
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i & !full_o & !clear_i;
    assign do_pop  = pop_i & !empty_o & !clear_i;

    // Next-state pointers and count; clear empties the queue, pointers wrap naturally
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            count_d  = {CNT_W{1'b0}};
        end else begin
            wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
            rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and count state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are only meaningful below the count
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Registered, back-pressured decode stage: queue -> combinational decode of
// the head -> output bundle register, gated by a register scoreboard.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int REG_SEL = 5,
    parameter int DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_inst,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4:0]           out_opcode,
    output logic [2:0]           out_cc,
    output logic                 out_is_branch,
    output logic                 out_is_neg_branch,
    output logic                 out_is_call,
    output logic                 out_is_ret,
    output logic                 out_is_halt,
    output logic                 out_a_bank,
    output logic                 out_a_from_rf,
    output logic [REG_SEL-1:0]   out_a_addr,
    output logic [DATA_W-1:0]    out_a_data,
    output logic                 out_b_bank,
    output logic                 out_b_from_rf,
    output logic [REG_SEL-1:0]   out_b_addr,
    output logic [DATA_W-1:0]    out_b_data,
    output logic                 out_z_bank,
    output logic [REG_SEL-1:0]   out_z_addr,
    output logic                 out_z_we,
    input  logic                 wb_valid,
    input  logic                 wb_bank,
    input  logic [REG_SEL-1:0]   wb_addr,
    output logic                 halted,
    output logic [$clog2(DEPTH):0] occupancy
);
    localparam int S_NUM = 2 ** REG_SEL;

    // Queue interface
    logic [31:0] head_inst;
    logic        fifo_full, fifo_empty;
    logic        push, issue, accept, hazard;

    // Decoded head bundle
    logic [4:0]         op;
    logic               d_alu, d_mov, d_br, d_call, d_ret, d_halt, d_cmp;
    logic               d_small, d_large;
    logic [2:0]         d_cc;
    logic               d_neg_branch;
    logic               d_a_bank, d_a_from_rf, d_b_from_rf, d_z_bank, d_z_we;
    logic [REG_SEL-1:0] d_a_addr, d_b_addr, d_z_addr;
    logic [DATA_W-1:0]  d_a_data, d_b_data;
    logic               unused_inst_bits;

    // Output bundle register
    logic               out_valid_q;
    logic [4:0]         out_opcode_q;
    logic [2:0]         out_cc_q;
    logic               out_is_branch_q, out_is_neg_branch_q, out_is_call_q;
    logic               out_is_ret_q, out_is_halt_q;
    logic               out_a_bank_q, out_a_from_rf_q, out_b_from_rf_q;
    logic               out_z_bank_q, out_z_we_q;
    logic [REG_SEL-1:0] out_a_addr_q, out_b_addr_q, out_z_addr_q;
    logic [DATA_W-1:0]  out_a_data_q, out_b_data_q;

    // Scoreboard and halt state
    logic [S_NUM-1:0] sb_s_q, sb_s_d;
    logic [P_NUM-1:0] sb_p_q, sb_p_d;
    logic             halted_q;

    // Scoreboard bit for a bank/address pair
    function automatic logic sb_hit(input logic bank, input logic [REG_SEL-1:0] addr,
                                    input logic [S_NUM-1:0] s_bits, input logic [P_NUM-1:0] p_bits);
        logic res;
        if (bank == P_REGS) res = p_bits[addr[2:0]];
        else                res = s_bits[addr];
        return res;
    endfunction

    // Same architectural register (predicate bank uses only 3 index bits)
    function automatic logic same_reg(input logic bank_x, input logic [REG_SEL-1:0] addr_x,
                                      input logic bank_y, input logic [REG_SEL-1:0] addr_y);
        logic res;
        if (bank_x != bank_y)      res = 1'b0;
        else if (bank_x == P_REGS) res = (addr_x[2:0] == addr_y[2:0]);
        else                       res = (addr_x == addr_y);
        return res;
    endfunction

    inst_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (flush),
        .push_i  (push),
        .wdata_i (in_inst),
        .pop_i   (issue),
        .rdata_o (head_inst),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (occupancy)
    );

    assign in_ready = !fifo_full & !flush & !halted_q;
    assign push     = in_valid & in_ready;
    assign accept   = out_valid_q & out_ready;
    assign unused_inst_bits = ^head_inst[24:21];

    // Combinational decode of the queue head
    always_comb begin
        op      = head_inst[OPC_HI:OPC_LO];
        d_alu   = is_alu_op(op);
        d_mov   = (op == OP_MOV);
        d_br    = (op == OP_BR);
        d_call  = (op == OP_CALL);
        d_ret   = (op == OP_RET);
        d_halt  = (op == OP_HALT);
        d_cmp   = (op == OP_CMP);
        d_small = d_alu & head_inst[IMM_BIT];
        d_large = d_mov | d_br | d_call;

        d_cc         = d_cmp ? head_inst[CC_HI:CC_LO] : 3'd0;
        d_neg_branch = d_br & head_inst[NEG_BIT];

        d_a_bank = d_br  ? P_REGS : S_REGS;
        d_z_bank = d_cmp ? P_REGS : S_REGS;

        if (d_br)        d_a_addr = REG_SEL'(head_inst[PA_HI:PA_LO]);
        else if (d_ret)  d_a_addr = REG_SEL'(R31);
        else if (d_mov)  d_a_addr = {REG_SEL{1'b0}};
        else             d_a_addr = REG_SEL'(head_inst[AA_HI:AA_LO]);

        d_b_addr = d_large ? {REG_SEL{1'b0}} : REG_SEL'(head_inst[BA_HI:BA_LO]);
        d_z_addr = d_call  ? REG_SEL'(R31)   : REG_SEL'(head_inst[ZA_HI:ZA_LO]);

        d_a_data = {{(DATA_W-16){head_inst[AD_HI]}}, head_inst[AD_HI:AD_LO]};
        if (!d_small)                d_b_data = {DATA_W{1'b0}};
        else if (head_inst[SX_BIT])  d_b_data = {{(DATA_W-5){head_inst[BA_HI]}}, head_inst[BA_HI:BA_LO]};
        else                         d_b_data = {{(DATA_W-5){1'b0}}, head_inst[BA_HI:BA_LO]};

        d_a_from_rf = !d_mov;
        d_b_from_rf = !d_small & !d_large;
        d_z_we      = d_alu | d_mov | d_call;
    end

    // Hazard: retired-pending scoreboard bits plus the write held in the
    // output register, which is not yet in the scoreboard
    always_comb begin
        hazard = 1'b0;
        if (d_a_from_rf && (sb_hit(d_a_bank, d_a_addr, sb_s_q, sb_p_q) ||
            (out_valid_q && out_z_we_q && same_reg(d_a_bank, d_a_addr, out_z_bank_q, out_z_addr_q))))
            hazard = 1'b1;
        else if (d_b_from_rf && (sb_hit(S_REGS, d_b_addr, sb_s_q, sb_p_q) ||
            (out_valid_q && out_z_we_q && same_reg(S_REGS, d_b_addr, out_z_bank_q, out_z_addr_q))))
            hazard = 1'b1;
        else if (d_z_we && (sb_hit(d_z_bank, d_z_addr, sb_s_q, sb_p_q) ||
            (out_valid_q && out_z_we_q && same_reg(d_z_bank, d_z_addr, out_z_bank_q, out_z_addr_q))))
            hazard = 1'b1;
        else
            hazard = 1'b0;
    end

    // Issue when the output slot frees up; nothing follows a HALT sitting in the slot
    assign issue = !fifo_empty & (!out_valid_q | out_ready) & !hazard & !halted_q &
                   !flush & !(out_valid_q & out_is_halt_q);

    // Scoreboard next state: accepted writes set, writebacks clear, set wins
    always_comb begin
        sb_s_d = sb_s_q;
        sb_p_d = sb_p_q;
        for (int i = 0; i < S_NUM; i++) begin
            sb_s_d[i] = (accept && out_z_we_q && out_z_bank_q == S_REGS && out_z_addr_q == REG_SEL'(i)) ||
                        (sb_s_q[i] && !(wb_valid && wb_bank == S_REGS && wb_addr == REG_SEL'(i)));
        end
        for (int i = 0; i < P_NUM; i++) begin
            sb_p_d[i] = (accept && out_z_we_q && out_z_bank_q == P_REGS && out_z_addr_q[2:0] == 3'(i)) ||
                        (sb_p_q[i] && !(wb_valid && wb_bank == P_REGS && wb_addr[2:0] == 3'(i)));
        end
    end

    // Scoreboard state; survives flush, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_s_q <= {S_NUM{1'b0}};
            sb_p_q <= {P_NUM{1'b0}};
        end else begin
            sb_s_q <= sb_s_d;
            sb_p_q <= sb_p_d;
        end
    end

    // Output valid: flush drops the bundle, issue fills it, consumption empties it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         out_valid_q <= 1'b0;
        else if (flush)     out_valid_q <= 1'b0;
        else if (issue)     out_valid_q <= 1'b1;
        else if (out_ready) out_valid_q <= 1'b0;
    end

    // Output bundle fields load only on issue, so they hold under back-pressure
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_opcode_q        <= 5'd0;
            out_cc_q            <= 3'd0;
            out_is_branch_q     <= 1'b0;
            out_is_neg_branch_q <= 1'b0;
            out_is_call_q       <= 1'b0;
            out_is_ret_q        <= 1'b0;
            out_is_halt_q       <= 1'b0;
            out_a_bank_q        <= 1'b0;
            out_a_from_rf_q     <= 1'b0;
            out_a_addr_q        <= {REG_SEL{1'b0}};
            out_a_data_q        <= {DATA_W{1'b0}};
            out_b_from_rf_q     <= 1'b0;
            out_b_addr_q        <= {REG_SEL{1'b0}};
            out_b_data_q        <= {DATA_W{1'b0}};
            out_z_bank_q        <= 1'b0;
            out_z_addr_q        <= {REG_SEL{1'b0}};
            out_z_we_q          <= 1'b0;
        end else if (issue) begin
            out_opcode_q        <= op;
            out_cc_q            <= d_cc;
            out_is_branch_q     <= d_br;
            out_is_neg_branch_q <= d_neg_branch;
            out_is_call_q       <= d_call;
            out_is_ret_q        <= d_ret;
            out_is_halt_q       <= d_halt;
            out_a_bank_q        <= d_a_bank;
            out_a_from_rf_q     <= d_a_from_rf;
            out_a_addr_q        <= d_a_addr;
            out_a_data_q        <= d_a_data;
            out_b_from_rf_q     <= d_b_from_rf;
            out_b_addr_q        <= d_b_addr;
            out_b_data_q        <= d_b_data;
            out_z_bank_q        <= d_z_bank;
            out_z_addr_q        <= d_z_addr;
            out_z_we_q          <= d_z_we;
        end
    end

    // Sticky halt once execute takes a HALT bundle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      halted_q <= 1'b0;
        else if (accept && out_is_halt_q) halted_q <= 1'b1;
    end

    assign out_valid         = out_valid_q;
    assign out_opcode        = out_opcode_q;
    assign out_cc            = out_cc_q;
    assign out_is_branch     = out_is_branch_q;
    assign out_is_neg_branch = out_is_neg_branch_q;
    assign out_is_call       = out_is_call_q;
    assign out_is_ret        = out_is_ret_q;
    assign out_is_halt       = out_is_halt_q;
    assign out_a_bank        = out_a_bank_q;
    assign out_a_from_rf     = out_a_from_rf_q;
    assign out_a_addr        = out_a_addr_q;
    assign out_a_data        = out_a_data_q;
    assign out_b_bank        = S_REGS;
    assign out_b_from_rf     = out_b_from_rf_q;
    assign out_b_addr        = out_b_addr_q;
    assign out_b_data        = out_b_data_q;
    assign out_z_bank        = out_z_bank_q;
    assign out_z_addr        = out_z_addr_q;
    assign out_z_we          = out_z_we_q;
    assign halted            = halted_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage.
module tb_decode_stage;
    localparam int DATA_W = 32;
    localparam int REG_SEL = 5;
    localparam int DEPTH = 4;

    localparam logic [4:0] T_ADD  = 5'd1;
    localparam logic [4:0] T_SUB  = 5'd2;
    localparam logic [4:0] T_CMP  = 5'd10;
    localparam logic [4:0] T_BR   = 5'd12;
    localparam logic [4:0] T_CALL = 5'd13;
    localparam logic [4:0] T_HALT = 5'd15;

    logic clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_inst;
    logic [4:0] out_opcode;
    logic [2:0] out_cc;
    logic out_is_branch, out_is_neg_branch, out_is_call, out_is_ret, out_is_halt;
    logic out_a_bank, out_a_from_rf, out_b_bank, out_b_from_rf, out_z_bank, out_z_we;
    logic [REG_SEL-1:0] out_a_addr, out_b_addr, out_z_addr, wb_addr;
    logic [DATA_W-1:0] out_a_data, out_b_data;
    logic wb_valid, wb_bank, halted;
    logic [$clog2(DEPTH):0] occupancy;

    int checks = 0;
    int errors = 0;

    decode_stage #(.DATA_W(DATA_W), .REG_SEL(REG_SEL), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_opcode(out_opcode), .out_cc(out_cc),
        .out_is_branch(out_is_branch), .out_is_neg_branch(out_is_neg_branch),
        .out_is_call(out_is_call), .out_is_ret(out_is_ret), .out_is_halt(out_is_halt),
        .out_a_bank(out_a_bank), .out_a_from_rf(out_a_from_rf),
        .out_a_addr(out_a_addr), .out_a_data(out_a_data),
        .out_b_bank(out_b_bank), .out_b_from_rf(out_b_from_rf),
        .out_b_addr(out_b_addr), .out_b_data(out_b_data),
        .out_z_bank(out_z_bank), .out_z_addr(out_z_addr), .out_z_we(out_z_we),
        .wb_valid(wb_valid), .wb_bank(wb_bank), .wb_addr(wb_addr),
        .halted(halted), .occupancy(occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] alu_w(input logic [4:0] op, input logic imm, input logic sx,
                                          input logic [4:0] z, input logic [4:0] a, input logic [4:0] b);
        return {op, imm, sx, 4'b0000, z, 6'b000000, a, b};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_inst = 32'd0;
        out_ready = 1'b0; wb_valid = 1'b0; wb_bank = 1'b0; wb_addr = 5'd0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic push_one(input logic [31:0] w);
        in_inst = w; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        push_one(alu_w(T_ADD, 1'b0, 1'b0, 5'd3, 5'd1, 5'd2));
        push_one(alu_w(T_ADD, 1'b0, 1'b0, 5'd4, 5'd1, 5'd2));
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
        checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL reset_occupancy: got %0d expected 0", occupancy); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %0b expected 0", halted); end
        checks++; if (out_z_we !== 1'b0) begin errors++; $display("FAIL reset_z_we: got %0b expected 0", out_z_we); end
        checks++; if (out_opcode !== 5'd0) begin errors++; $display("FAIL reset_opcode: got %0d expected 0", out_opcode); end
    endtask

    task automatic test_basic;
        int waited;
        do_reset();
        out_ready = 1'b1;
        push_one(alu_w(T_ADD, 1'b0, 1'b0, 5'd3, 5'd1, 5'd2));
        waited = 0;
        while (out_valid !== 1'b1 && waited < 2) begin tick(); waited++; end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %0b expected 1 within 2 cycles", out_valid); end
        checks++; if (out_a_addr !== 5'd1) begin errors++; $display("FAIL basic_a_addr: got %0d expected 1", out_a_addr); end
        checks++; if (out_b_addr !== 5'd2) begin errors++; $display("FAIL basic_b_addr: got %0d expected 2", out_b_addr); end
        checks++; if (out_z_addr !== 5'd3) begin errors++; $display("FAIL basic_z_addr: got %0d expected 3", out_z_addr); end
        checks++; if (out_z_we !== 1'b1) begin errors++; $display("FAIL basic_z_we: got %0b expected 1", out_z_we); end
        checks++; if (out_b_from_rf !== 1'b1 || out_a_from_rf !== 1'b1) begin errors++; $display("FAIL basic_from_rf: got a=%0b b=%0b expected 1/1", out_a_from_rf, out_b_from_rf); end
        checks++; if (out_a_data !== 32'h0000_0022) begin errors++; $display("FAIL basic_a_data: got %h expected 00000022", out_a_data); end
        checks++; if (out_b_bank !== 1'b0 || out_z_bank !== 1'b0 || out_opcode !== T_ADD) begin errors++; $display("FAIL basic_banks_op: got b=%0b z=%0b op=%0d expected 0/0/1", out_b_bank, out_z_bank, out_opcode); end
    endtask

    task automatic test_imm;
        do_reset();
        out_ready = 1'b1;
        push_one(alu_w(T_ADD, 1'b1, 1'b1, 5'd5, 5'd0, 5'b11110));
        push_one(alu_w(T_ADD, 1'b1, 1'b0, 5'd6, 5'd0, 5'b11110));
        checks++; if (out_b_data !== 32'hFFFF_FFFE) begin errors++; $display("FAIL imm_sext_data: got %h expected fffffffe", out_b_data); end
        checks++; if (out_b_from_rf !== 1'b0) begin errors++; $display("FAIL imm_sext_from_rf: got %0b expected 0", out_b_from_rf); end
        checks++; if (out_z_we !== 1'b1 || out_z_addr !== 5'd5) begin errors++; $display("FAIL imm_sext_dest: got we=%0b z=%0d expected 1/5", out_z_we, out_z_addr); end
        tick();
        checks++; if (out_b_data !== 32'h0000_001E) begin errors++; $display("FAIL imm_zext_data: got %h expected 0000001e", out_b_data); end
        checks++; if (out_b_from_rf !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL imm_zext_flags: got rf=%0b v=%0b expected 0/1", out_b_from_rf, out_valid); end
    endtask

    task automatic test_branch_call;
        do_reset();
        out_ready = 1'b1;
        push_one({T_BR, 7'd0, 1'b1, 3'd3, 16'h8001});
        push_one({T_CMP, 2'b00, 4'd0, 5'd2, 3'd0, 3'd5, 5'd1, 5'd2});
        checks++; if (out_is_branch !== 1'b1 || out_is_neg_branch !== 1'b1) begin errors++; $display("FAIL br_flags: got br=%0b neg=%0b expected 1/1", out_is_branch, out_is_neg_branch); end
        checks++; if (out_a_bank !== 1'b1 || out_a_addr !== 5'd3) begin errors++; $display("FAIL br_a_src: got bank=%0b addr=%0d expected 1/3", out_a_bank, out_a_addr); end
        checks++; if (out_a_data !== 32'hFFFF_8001) begin errors++; $display("FAIL br_a_data: got %h expected ffff8001", out_a_data); end
        checks++; if (out_b_from_rf !== 1'b0 || out_b_addr !== 5'd0 || out_z_we !== 1'b0) begin errors++; $display("FAIL br_b_z: got rf=%0b addr=%0d we=%0b expected 0/0/0", out_b_from_rf, out_b_addr, out_z_we); end
        push_one({T_CALL, 11'd0, 16'h0010});
        checks++; if (out_cc !== 3'd5) begin errors++; $display("FAIL cmp_cc: got %0d expected 5", out_cc); end
        checks++; if (out_z_bank !== 1'b1 || out_z_addr !== 5'd2 || out_is_branch !== 1'b0) begin errors++; $display("FAIL cmp_dest: got bank=%0b z=%0d br=%0b expected 1/2/0", out_z_bank, out_z_addr, out_is_branch); end
        tick();
        checks++; if (out_is_call !== 1'b1 || out_is_ret !== 1'b0) begin errors++; $display("FAIL call_flags: got call=%0b ret=%0b expected 1/0", out_is_call, out_is_ret); end
        checks++; if (out_z_addr !== 5'd31 || out_z_we !== 1'b1 || out_cc !== 3'd0) begin errors++; $display("FAIL call_dest: got z=%0d we=%0b cc=%0d expected 31/1/0", out_z_addr, out_z_we, out_cc); end
    endtask

    task automatic test_hazard;
        do_reset();
        out_ready = 1'b1;
        push_one(alu_w(T_ADD, 1'b0, 1'b0, 5'd3, 5'd1, 5'd2));
        push_one(alu_w(T_SUB, 1'b0, 1'b0, 5'd4, 5'd3, 5'd1));
        checks++; if (out_valid !== 1'b1 || out_opcode !== T_ADD) begin errors++; $display("FAIL haz_add_out: got v=%0b op=%0d expected 1/1", out_valid, out_opcode); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL haz_sub_held1: got %0b expected 0", out_valid); end
        repeat (2) tick();
        checks++; if (out_valid !== 1'b0 || occupancy !== 3'd1) begin errors++; $display("FAIL haz_sub_held2: got v=%0b occ=%0d expected 0/1", out_valid, occupancy); end
        wb_valid = 1'b1; wb_bank = 1'b0; wb_addr = 5'd3;
        tick();
        wb_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL haz_wb_edge: got %0b expected 0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_opcode !== T_SUB) begin errors++; $display("FAIL haz_sub_issue: got v=%0b op=%0d expected 1/2", out_valid, out_opcode); end
        checks++; if (out_z_addr !== 5'd4 || out_a_addr !== 5'd3) begin errors++; $display("FAIL haz_sub_regs: got z=%0d a=%0d expected 4/3", out_z_addr, out_a_addr); end
    endtask

    task automatic test_full;
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i <= DEPTH; i++) begin
            in_inst = alu_w(T_ADD, 1'b0, 1'b0, 5'(10 + i), 5'd0, 5'd0);
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        checks++; if (occupancy !== 3'(DEPTH)) begin errors++; $display("FAIL full_occ: got %0d expected %0d", occupancy, DEPTH); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready: got %0b expected 0", in_ready); end
        checks++; if (out_valid !== 1'b1 || out_z_addr !== 5'd10) begin errors++; $display("FAIL full_out: got v=%0b z=%0d expected 1/10", out_valid, out_z_addr); end
        in_inst = alu_w(T_ADD, 1'b0, 1'b0, 5'd20, 5'd0, 5'd0);
        in_valid = 1'b1;
        tick();
        checks++; if (occupancy !== 3'(DEPTH)) begin errors++; $display("FAIL full_extra_occ: got %0d expected %0d", occupancy, DEPTH); end
        checks++; if (out_z_addr !== 5'd10 || out_valid !== 1'b1) begin errors++; $display("FAIL full_stable: got v=%0b z=%0d expected 1/10", out_valid, out_z_addr); end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_pop_in_ready: got %0b expected 0", in_ready); end
        tick();
        checks++; if (occupancy !== 3'd3 || in_ready !== 1'b1) begin errors++; $display("FAIL full_after_pop: got occ=%0d rdy=%0b expected 3/1", occupancy, in_ready); end
        checks++; if (out_z_addr !== 5'd11) begin errors++; $display("FAIL full_next_out: got z=%0d expected 11", out_z_addr); end
        out_ready = 1'b0;
        in_valid = 1'b0;
    endtask

    // Continues from test_full: 3 queued, one bundle held, r10 pending in scoreboard
    task automatic test_flush;
        flush = 1'b1;
        in_valid = 1'b1;
        in_inst = alu_w(T_ADD, 1'b0, 1'b0, 5'd21, 5'd0, 5'd0);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %0b expected 0", in_ready); end
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL flush_occ: got %0d expected 0", occupancy); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid: got %0b expected 0", out_valid); end
        out_ready = 1'b1;
        push_one(alu_w(T_ADD, 1'b0, 1'b0, 5'd22, 5'd10, 5'd0));
        repeat (2) tick();
        checks++; if (out_valid !== 1'b0 || occupancy !== 3'd1) begin errors++; $display("FAIL flush_sb_kept: got v=%0b occ=%0d expected 0/1", out_valid, occupancy); end
        wb_valid = 1'b1; wb_bank = 1'b0; wb_addr = 5'd10;
        tick();
        wb_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b1 || out_z_addr !== 5'd22) begin errors++; $display("FAIL flush_release: got v=%0b z=%0d expected 1/22", out_valid, out_z_addr); end
    endtask

    task automatic test_halt;
        do_reset();
        out_ready = 1'b1;
        push_one({T_HALT, 27'd0});
        push_one(alu_w(T_ADD, 1'b0, 1'b0, 5'd7, 5'd1, 5'd2));
        checks++; if (out_is_halt !== 1'b1 || out_valid !== 1'b1) begin errors++; $display("FAIL halt_out: got h=%0b v=%0b expected 1/1", out_is_halt, out_valid); end
        tick();
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_set: got %0b expected 1", halted); end
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL halt_block: got rdy=%0b v=%0b expected 0/0", in_ready, out_valid); end
        repeat (3) tick();
        checks++; if (out_valid !== 1'b0 || occupancy !== 3'd1) begin errors++; $display("FAIL halt_no_issue: got v=%0b occ=%0d expected 0/1", out_valid, occupancy); end
        in_inst = alu_w(T_ADD, 1'b0, 1'b0, 5'd8, 5'd1, 5'd2);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++; if (occupancy !== 3'd1 || halted !== 1'b1) begin errors++; $display("FAIL halt_no_push: got occ=%0d h=%0b expected 1/1", occupancy, halted); end
        do_reset();
        checks++; if (halted !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL halt_reset: got h=%0b rdy=%0b expected 0/1", halted, in_ready); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_imm();
        test_branch_call();
        test_hazard();
        test_full();
        test_flush();
        test_halt();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
